obstacle_gen: RTL and testbench
===============================

Name: obstacle_gen

Overview:
- Generates the cactus obstacles for the dinosaur game and supplies a per-pixel "obstacle present" bit to the VGA pixel mux, alongside px_dinosaur and px_ground.
- Up to N_SLOTS obstacles are spawned at the right screen edge with pseudo-random gaps and heights.
- Obstacles scroll left once per frame by `speed` pixels and are retired once fully off-screen.
- Shares the frame strobe (vs), row_addr/col_addr, game_status and speed with the Jump and Ground blocks.

Parameters:
- N_SLOTS, 3, number of concurrent obstacle slots.
- MIN_GAP, 40, minimum frames between spawns.
- GAP_MASK_W, 6, LFSR bits added to MIN_GAP for the random gap (0..63 extra frames).
- LFSR_SEED, 16'hACE1, LFSR reset value. Must be non-zero.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  synchronous, active-low reset.
- fresh  input  1  vs from the VGA block; a rising edge marks a frame tick.
- row_addr  input  9  current scan row.
- col_addr  input  10  current scan column.
- game_status  input  1  1 = running; 0 = stopped or game over (freeze).
- speed  input  4  scroll pixels per frame.
- px  output  1  1 when the current pixel lies inside any active obstacle.
- active  output  N_SLOTS  slot-occupied flags, for collision and score logic.

Behaviour:
- Reset (RESET=0 at a CLK edge, takes priority over everything):
  - px=0, active=0, all x=0.
  - gap_cnt=MIN_GAP, lfsr=LFSR_SEED, fresh_d=0.
  - Applies mid-frame or mid-tick with no exceptions.
- Frame tick: tick = fresh & ~fresh_d, where fresh_d is fresh registered on CLK. vs is synchronous to CLK, so no synchronizer is used. Exactly one tick per vs rising edge.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every CLK cycle when not in reset, independent of game_status.
- Per-slot state: active bit, x as 11-bit signed left edge, tall bit.
- Obstacle geometry:
  - Width CACTUS_W=16.
  - Height H_SMALL=32 when tall=0, H_TALL=48 when tall=1.
  - Bottom edge on GROUND_Y=400.
- On tick with game_status=1, all updates happen in the same cycle:
  - Move: every active slot takes x <= x - speed. Arithmetic is 11-bit signed; speed is zero-extended.
  - Retire: if the new x < -CACTUS_W, clear the slot's active bit in that same cycle.
  - Gap counter: if gap_cnt != 0, decrement it.
  - Spawn: if gap_cnt == 0, pick the lowest-index slot that was inactive before this tick.
    - If one exists: active=1, x=SCREEN_W (640, not moved this tick), tall=lfsr[6], gap_cnt <= MIN_GAP + lfsr[GAP_MASK_W-1:0].
    - If none exists: gap_cnt holds at 0 and the spawn is retried on each later tick.
  - A slot retired on this tick is not reusable until the next tick.
- On tick with game_status=0: x, active and gap_cnt all hold.
- speed=0: no movement. Spawning still follows gap_cnt.
- Pixel output, registered with 1 CLK latency from row_addr/col_addr. px=1 iff some active slot satisfies:
  - x <= col < x+CACTUS_W, with col zero-extended to 11-bit signed; and
  - GROUND_Y-H <= row < GROUND_Y.
- Off-screen parts (x<0 or x+W>640) simply never match a visible col, so no clipping logic is needed.
- Updating positions during the visible area is allowed. A tick lies in vertical blanking, so no mid-frame tearing occurs.

Decomposition:
- Package dino_pkg holds SCREEN_W=640, GROUND_Y=400, CACTUS_W=16, H_SMALL=32, H_TALL=48, and the coordinate widths XW=11, ROW_W=9, COL_W=10. The package is shared with Jump and Ground for the ground line and hitbox math.
- One sub-module: obstacle_lfsr (seed parameter, enable, 16-bit state out).
- The per-slot compare is a generate loop in obstacle_gen.

Test Plan:
1. Reset, game_status=1, speed=4, pulse fresh repeatedly.
   - active stays 0 for ticks 1..40.
   - Tick 41: active[0]=1, x0=640.
2. Continuing from 1, after 10 more ticks x0=600.
   - Drive row=399, col=600: px=1 one cycle later.
   - col=616 -> px=0; row=400 -> px=0.
   - row=368 with tall=0 -> px=1; row=367 -> px=0.
3. game_status=0 for 20 ticks: x0, active and gap_cnt unchanged.
   - Set game_status=1: the next tick moves x0 by 4.
4. Force x0=-12, speed=5, one tick: x0=-17, so active[0] clears the same cycle and px never asserts for that slot again.
5. All 3 slots active with gap_cnt=0: ticks leave gap_cnt=0 and spawn nothing. The first tick after a slot retires spawns into that slot, the lowest-index free one.
6. RESET=0 for one edge mid-play with obstacles visible:
   - Next cycle: active=0, px=0, gap_cnt=40, lfsr=16'hACE1.
   - Re-run scenario 1: identical spawn timing and tall value.

Source files
------------

// File: rtl/dino_pkg.sv
// dino_pkg: screen geometry and coordinate widths shared by the dinosaur-game
// blocks (obstacle generator, jump and ground). There are no ports; other files
// pull it in with import dino_pkg::*.
//   SCREEN_W / GROUND_Y  visible width and the row of the ground line
//   CACTUS_W / H_*       obstacle hitbox width and the two obstacle heights
//   XW / ROW_W / COL_W   signed x width, scan row width and scan column width
package dino_pkg;

   localparam int SCREEN_W = 640;
   localparam int GROUND_Y = 400;
   localparam int CACTUS_W = 16;
   localparam int H_SMALL  = 32;
   localparam int H_TALL   = 48;
   localparam int XW       = 11;
   localparam int ROW_W    = 9;
   localparam int COL_W    = 10;
   localparam int LFSR_W   = 16;

   // First (topmost) row covered by an obstacle of the given height class.
   function automatic logic [ROW_W-1:0] cactus_top(input logic tall);
      cactus_top = tall ? ROW_W'(GROUND_Y - H_TALL) : ROW_W'(GROUND_Y - H_SMALL);
   endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// obstacle_lfsr: 16-bit Fibonacci LFSR with taps 16,14,13,11. It supplies the
// random gap and height bits for obstacle spawning.
// Ports:
//   clk    system clock, posedge
//   rst_n  synchronous active-low reset; loads SEED
//   en     advance one step on this clock edge
//   state  current register contents
module obstacle_lfsr
   import dino_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic [LFSR_W-1:0] state
);

   // Shift right. Taps 16,14,13,11 are bits 0,2,3,5 of the right-shifting form.
   logic feedback;
   assign feedback = state[0] ^ state[2] ^ state[3] ^ state[5];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (en) begin
         state <= {feedback, state[LFSR_W-1:1]};
      end
   end

endmodule

// File: rtl/obstacle_gen.sv
// obstacle_gen: spawns, scrolls and retires the cactus obstacles. It also
// produces the registered per-pixel "obstacle present" bit for the VGA mux.
// Ports:
//   CLK          system clock, all logic on posedge
//   RESET        synchronous active-low reset
//   fresh        VS from the VGA block; its rising edge is the frame tick
//   row_addr     current scan row
//   col_addr     current scan column
//   game_status  1 = running, 0 = frozen (stopped or game over)
//   speed        scroll distance in pixels per frame
//   px           1 when the pixel addressed one cycle earlier lies in an obstacle
//   active       slot-occupied flags
module obstacle_gen
   import dino_pkg::*;
#(
   parameter int              N_SLOTS    = 3,
   parameter int              MIN_GAP    = 40,
   parameter int              GAP_MASK_W = 6,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               fresh,
   input  logic [ROW_W-1:0]   row_addr,
   input  logic [COL_W-1:0]   col_addr,
   input  logic               game_status,
   input  logic [3:0]         speed,
   output logic               px,
   output logic [N_SLOTS-1:0] active
);

   // Wide enough for the largest reload value MIN_GAP + (2**GAP_MASK_W - 1).
   localparam int GW = $clog2(MIN_GAP + (1 << GAP_MASK_W));

   localparam logic signed [XW-1:0] RETIRE_X = XW'(-CACTUS_W);
   localparam logic signed [XW:0]   CW_S     = (XW+1)'(CACTUS_W);

   logic                          fresh_d;
   logic                          tick;
   logic                          run;
   logic [LFSR_W-1:0]             lfsr;
   logic                          lfsr_unused;
   logic [GW-1:0]                 gap_cnt;
   logic [GW-1:0]                 gap_nxt;
   logic [N_SLOTS-1:0][XW-1:0]    x;
   logic [N_SLOTS-1:0][XW-1:0]    x_nxt;
   logic [N_SLOTS-1:0][XW-1:0]    moved;
   logic [N_SLOTS-1:0]            tall;
   logic [N_SLOTS-1:0]            tall_nxt;
   logic [N_SLOTS-1:0]            active_nxt;
   logic [N_SLOTS-1:0]            spawn_sel;
   logic                          taken;
   logic [N_SLOTS-1:0]            hit;

   // VS is already synchronous to CLK, so a single register gives the edge.
   assign tick = fresh & ~fresh_d;
   assign run  = tick & game_status;

   obstacle_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (CLK),
      .rst_n (RESET),
      .en    (1'b1),
      .state (lfsr)
   );

   // Only a few LFSR bits feed the spawn logic; the rest are intentionally idle.
   assign lfsr_unused = ^lfsr;

   // One-hot pick of the lowest-index slot that is free before this tick. A
   // slot retiring on this same tick is still flagged active here, so it only
   // becomes reusable on the following tick.
   always_comb begin
      spawn_sel = '0;
      taken     = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         spawn_sel[i] = ~active[i] & ~taken;
         taken        = taken | ~active[i];
      end
   end

   always_comb begin
      x_nxt      = x;
      tall_nxt   = tall;
      active_nxt = active;
      gap_nxt    = gap_cnt;
      moved      = '0;
      if (run) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            moved[i] = x[i] - XW'(speed);
            if (active[i]) begin
               x_nxt[i] = moved[i];
               if ($signed(moved[i]) < RETIRE_X) begin
                  active_nxt[i] = 1'b0;
               end
            end
         end
         if (gap_cnt != '0) begin
            gap_nxt = gap_cnt - GW'(1);
         end else if (taken) begin
            // A new obstacle starts just past the right edge and is not moved
            // on its spawn tick.
            for (int i = 0; i < N_SLOTS; i++) begin
               if (spawn_sel[i]) begin
                  active_nxt[i] = 1'b1;
                  x_nxt[i]      = XW'(SCREEN_W);
                  tall_nxt[i]   = lfsr[6];
               end
            end
            gap_nxt = GW'(MIN_GAP) + GW'(lfsr[GAP_MASK_W-1:0]);
         end
         // With no free slot gap_cnt stays 0 and the spawn is retried next tick.
      end
   end

   // Per-slot hit test. The column is zero-extended into the signed x domain,
   // so parts of an obstacle left of 0 or right of 639 never match.
   for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
      logic signed [XW:0] left;
      logic signed [XW:0] right;
      logic signed [XW:0] col_s;
      logic               col_hit;
      logic               row_hit;

      assign left    = {x[g][XW-1], x[g]};
      assign right   = left + CW_S;
      assign col_s   = {2'b00, col_addr};
      assign col_hit = (col_s >= left) && (col_s < right);
      assign row_hit = (row_addr >= cactus_top(tall[g])) &&
                       (row_addr <  ROW_W'(GROUND_Y));
      assign hit[g]  = active[g] & col_hit & row_hit;
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         fresh_d <= 1'b0;
         active  <= '0;
         x       <= '0;
         tall    <= '0;
         gap_cnt <= GW'(MIN_GAP);
         px      <= 1'b0;
      end else begin
         fresh_d <= fresh;
         active  <= active_nxt;
         x       <= x_nxt;
         tall    <= tall_nxt;
         gap_cnt <= gap_nxt;
         px      <= |hit;
      end
   end

endmodule

// File: tb/tb_obstacle_gen.sv
// tb_obstacle_gen: directed bench for obstacle_gen. It covers reset, the spawn
// schedule, scrolling, the pixel window, freezing, retirement, slot exhaustion
// and a mid-play reset.
module tb_obstacle_gen;

   logic       clk;
   logic       rst_n;
   logic       fresh;
   logic [8:0] row_addr;
   logic [9:0] col_addr;
   logic       game_status;
   logic [3:0] speed;
   logic       px;
   logic [2:0] active;

   int checks = 0;
   int errors = 0;

   // Reference state for the spawn/scroll rules
   logic [15:0] m_lfsr;
   logic [2:0]  m_act;
   logic [2:0]  m_tall;
   int          m_x [3];
   int          m_gap;
   logic [15:0] tl;

   logic [0:0] exp_q[$];

   logic       first_tall;
   int         first_gap;
   int         vis;
   int         g_before;

   obstacle_gen dut (
      .CLK         (clk),
      .RESET       (rst_n),
      .fresh       (fresh),
      .row_addr    (row_addr),
      .col_addr    (col_addr),
      .game_status (game_status),
      .speed       (speed),
      .px          (px),
      .active      (active)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: right-shifting Fibonacci form, feedback from bits 0,2,3,5.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return (s >> 1) | ({15'b0, fb} << 15);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      m_act  = 3'b000;
      m_tall = 3'b000;
      m_gap  = 40;
      for (int i = 0; i < 3; i++) m_x[i] = 0;
   endtask

   task automatic model_tick(input logic [15:0] l);
      int free;
      if (game_status) begin
         free = -1;
         for (int i = 0; i < 3; i++) if (!m_act[i] && free < 0) free = i;
         for (int i = 0; i < 3; i++) begin
            if (m_act[i]) begin
               m_x[i] = m_x[i] - int'(speed);
               if (m_x[i] < -16) m_act[i] = 1'b0;
            end
         end
         if (m_gap != 0) begin
            m_gap = m_gap - 1;
         end else if (free >= 0) begin
            m_act[free]  = 1'b1;
            m_x[free]    = 640;
            m_tall[free] = l[6];
            m_gap        = 40 + int'(l[5:0]);
         end
      end
   endtask

   function automatic logic model_px(input int row, input int col);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (m_act[i] && col >= m_x[i] && col < m_x[i] + 16 &&
             row >= 400 - (m_tall[i] ? 48 : 32) && row < 400) r = 1'b1;
      end
      return r;
   endfunction

   // ---------------- drivers ----------------
   task automatic do_tick();
      @(negedge clk);
      fresh = 1'b1;
      tl    = m_lfsr;
      model_tick(tl);
      @(negedge clk);
      fresh = 1'b0;
      @(negedge clk);
   endtask

   // fresh held high for several cycles still gives exactly one tick
   task automatic do_long_tick();
      @(negedge clk);
      fresh = 1'b1;
      tl    = m_lfsr;
      model_tick(tl);
      repeat (4) @(negedge clk);
      fresh = 1'b0;
      @(negedge clk);
   endtask

   task automatic pix(input string tag, input int row, input int col, input logic exp);
      @(negedge clk);
      row_addr = 9'(row);
      col_addr = 10'(col);
      exp_q.push_back(exp);
      @(negedge clk);
      check(tag, px, exp_q.pop_front());
   endtask

   task automatic check_slots(input string tag);
      check({tag, "_active"}, active, m_act);
      check({tag, "_gap"}, dut.gap_cnt, m_gap);
      for (int i = 0; i < 3; i++) begin
         if (m_act[i]) check({tag, "_x"}, $signed(dut.x[i]), m_x[i]);
      end
   endtask

   // Reset release, 40 quiet ticks, first spawn on tick 41.
   task automatic run_spawn_seq();
      @(negedge clk);
      check("lfsr_step1", dut.lfsr, 16'h5670);
      for (int t = 1; t <= 40; t++) begin
         do_tick();
         check("idle_active", active, 0);
         if (t == 1) check("gap_tick1", dut.gap_cnt, 39);
      end
      check("gap_tick40", dut.gap_cnt, 0);
      do_tick();
      check("spawn_active", active, 3'b001);
      check("spawn_x0", $signed(dut.x[0]), 640);
      check("spawn_tall", dut.tall[0], m_tall[0]);
      check("spawn_gap", dut.gap_cnt, m_gap);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n       = 1'b0;
      fresh       = 1'b0;
      game_status = 1'b1;
      speed       = 4'd4;
      row_addr    = '0;
      col_addr    = '0;
      model_reset();

      // 1: reset and first spawn
      repeat (3) @(negedge clk);
      check("rst_active", active, 0);
      check("rst_px", px, 0);
      check("rst_gap", dut.gap_cnt, 40);
      check("rst_lfsr", dut.lfsr, 16'hACE1);
      check("rst_x0", $signed(dut.x[0]), 0);
      rst_n = 1'b1;
      run_spawn_seq();
      first_tall = m_tall[0];
      first_gap  = m_gap;

      // 2: scroll 10 ticks at speed 4, then probe the pixel window
      for (int t = 0; t < 9; t++) do_tick();
      do_long_tick();
      check("scroll_x0", $signed(dut.x[0]), 600);
      check("scroll_active", active, 3'b001);
      pix("px_399_600", 399, 600, 1'b1);
      pix("px_399_615", 399, 615, 1'b1);
      pix("px_399_616", 399, 616, 1'b0);
      pix("px_399_599", 399, 599, 1'b0);
      pix("px_400_600", 400, 600, 1'b0);
      pix("px_368_600", 368, 600, 1'b1);
      pix("px_367_600", 367, 600, m_tall[0]);
      pix("px_352_600", 352, 600, m_tall[0]);
      pix("px_351_600", 351, 600, 1'b0);

      // 3: freeze for 20 ticks, then resume
      g_before    = m_gap;
      game_status = 1'b0;
      for (int t = 0; t < 20; t++) do_tick();
      check("frz_x0", $signed(dut.x[0]), 600);
      check("frz_active", active, 3'b001);
      check("frz_gap", dut.gap_cnt, g_before);
      game_status = 1'b1;
      do_tick();
      check("resume_x0", $signed(dut.x[0]), 596);
      check("resume_gap", dut.gap_cnt, g_before - 1);

      // 4: walk slot 0 to x=-12, then one tick at speed 5 retires it
      speed = 4'd15;
      for (int t = 0; t < 60 && (m_x[0] - 15 >= -12); t++) do_tick();
      speed = 4'(m_x[0] + 12);
      do_tick();
      check("edge_x0", $signed(dut.x[0]), -12);
      check("edge_act0", active[0], 1);
      speed = 4'd5;
      do_tick();
      check("retire_x0", $signed(dut.x[0]), -17);
      check("retire_act0", active[0], 0);
      check_slots("retire");
      pix("retired_px_c0", 399, 0, model_px(399, 0));
      pix("retired_px_c5", 399, 5, model_px(399, 5));

      // 5: fill every slot at speed 0 until the gap runs out
      speed = 4'd0;
      for (int t = 0; t < 400 && !(m_act == 3'b111 && m_gap == 0); t++) do_tick();
      check("full_active", active, 3'b111);
      check("full_gap", dut.gap_cnt, 0);
      do_tick();
      do_tick();
      check("full_hold_active", active, 3'b111);
      check("full_hold_gap", dut.gap_cnt, 0);
      check_slots("full");
      speed = 4'd15;
      for (int t = 0; t < 100 && m_act == 3'b111; t++) do_tick();
      check("retire_seen", active == 3'b111, 0);
      check("retire_hold_gap", dut.gap_cnt, 0);
      check_slots("full_retire");
      do_tick();
      check_slots("respawn");

      // 6: mid-play reset with an obstacle on screen, then replay scenario 1
      vis = -1;
      for (int t = 0; t < 80 && vis < 0; t++) begin
         do_tick();
         for (int i = 0; i < 3; i++) begin
            if (vis < 0 && m_act[i] && m_x[i] >= 0 && m_x[i] <= 620) vis = i;
         end
      end
      check("visible_found", vis >= 0, 1);
      if (vis >= 0) pix("pre_reset_px", 399, m_x[vis], 1'b1);
      speed = 4'd4;
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      check("mid_rst_active", active, 0);
      check("mid_rst_px", px, 0);
      check("mid_rst_gap", dut.gap_cnt, 40);
      check("mid_rst_lfsr", dut.lfsr, 16'hACE1);
      rst_n = 1'b1;
      run_spawn_seq();
      check("replay_tall", dut.tall[0], first_tall);
      check("replay_gap", dut.gap_cnt, first_gap);

      // ---------------- report ----------------
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
